fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the multi-cycle / pipelined CPU core. Owns the architectural PC register, issues one instruction-memory request at a time over a req/ack handshake, and buffers the returned instruction for decode. It applies redirects computed downstream by the next-PC unit (taken branch, JAL, JALR), and discards any fetch that was in flight when the redirect arrived.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  one-cycle pulse: change fetch stream
- redirect_pc  in  32  target from next-PC unit
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, stable while imem_req high
- imem_ack  in  1  response valid, imem_rdata sampled this cycle
- imem_rdata  in  32  instruction word
- if_valid  out  1  if_pc/if_inst hold a valid instruction
- if_pc  out  32  PC of buffered instruction
- if_inst  out  32  buffered instruction
- if_ready  in  1  decode accepts buffer this cycle
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Registers:
  - pc (fetch address)
  - pend_pc (redirect target held during drain)
  - output buffer {if_valid, if_pc, if_inst}
  - state: ST_IDLE, ST_REQ, ST_DRAIN
- imem_req = (state != ST_IDLE); imem_addr = pc.
- space = !if_valid || if_ready.
- Redirect has priority over every other event. Any redirect clears if_valid in the same edge, even if if_ready is high.
- ST_IDLE:
  - redirect: pc <= redirect_pc, stay ST_IDLE.
  - else if space: -> ST_REQ.
- ST_REQ:
  - redirect & imem_ack: drop rdata, pc <= redirect_pc, -> ST_IDLE.
  - redirect & !imem_ack: pend_pc <= redirect_pc, -> ST_DRAIN. pc is unchanged so the address stays stable.
  - imem_ack only: buffer <= {1, pc, imem_rdata}, pc <= pc + 4 (mod 2^32, wraps at 32'hFFFF_FFFC), -> ST_IDLE.
  - Otherwise hold.
- ST_DRAIN:
  - redirect: pend_pc <= redirect_pc; the last redirect wins.
  - imem_ack: drop rdata, pc <= (redirect this cycle ? redirect_pc : pend_pc), -> ST_IDLE.
- Consumption: if_valid & if_ready with no redirect -> if_valid <= 0, unless an ack loads the buffer on the same edge. Ack is only processed in ST_REQ, which is entered only with space, so no overwrite of unconsumed data can occur.

## Timing
- Reset values:
  - pc = RESET_PC, pend_pc = 0
  - state = ST_IDLE
  - imem_req = 0, if_valid = 0, if_pc = 0, if_inst = 0
  - misalign_err = 0
- An outstanding request is abandoned on reset; memory shares the same rst.
- First imem_req is seen on the first cycle after rst deasserts.
- Request-to-buffer latency: if_valid rises on the edge that samples imem_ack.
- Peak throughput: 1 instruction per 2 cycles with zero-wait memory (ST_REQ/ST_IDLE alternation).
- Redirect-to-new-request: 1 cycle from ST_IDLE or ST_REQ+ack. From ST_DRAIN, 1 cycle after the draining ack.
- imem_addr changes only on cycles where imem_req is low or imem_ack is high.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 is ignored entirely: no flush, no state or pc change.
  - It sets misalign_err, which stays set until rst.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00 before use.
  - misalign_err is tied 0.

## Structure
- Shared package (cpu defines file): state encodings ST_IDLE/ST_REQ/ST_DRAIN (2 bits) and the instruction width constant.
- RESET_PC stays a module parameter.
- One natural sub-module: fetch_buf (single-entry valid/pc/inst holding register with load/consume/flush inputs). Everything else stays in fetch_ctrl.

## Test plan
- Reset, zero-wait ack, if_ready=1 -> if_pc sequence 0x0, 0x4, 0x8 with if_valid high every other cycle.
- if_ready=0 for 5 cycles with a valid buffer -> imem_req stays 0; if_pc/if_inst hold; fetch resumes the cycle after if_ready=1.
- imem_ack delayed 3 cycles; redirect to 0x100 in cycle 1 of the wait -> the ack's data is dropped, the next imem_addr is 0x100, and if_valid is never set for the old pc.
- Two redirects (0x200, then 0x300) during one drain -> the next request address is 0x300.
- Redirect coinciding with ack and if_ready=1 -> buffer flushed, pc=target, no instruction delivered that cycle.
- Redirect to 0x102:
  - With FETCH_MISALIGN_CHECK_EN: misalign_err=1, stream unchanged.
  - Without it: fetch from 0x100.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU fetch definitions: fetch FSM encodings and instruction width.
package fetch_ctrl_pkg;

  localparam int unsigned InstWidth = 32;
  localparam int unsigned PcWidth   = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

  function automatic logic [PcWidth-1:0] next_seq_pc(input logic [PcWidth-1:0] pc);
    return pc + PcWidth'(4);
  endfunction

endpackage

// File: rtl/fetch_ctrl_buf.sv
// Single-entry fetch output buffer holding {valid, pc, inst}; flush beats load beats consume.
module fetch_buf
  import fetch_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 consume,
  input  logic                 flush,
  input  logic [PcWidth-1:0]   load_pc,
  input  logic [InstWidth-1:0] load_inst,
  output logic                 valid,
  output logic [PcWidth-1:0]   pc,
  output logic [InstWidth-1:0] inst
);

  logic                 valid_q;
  logic [PcWidth-1:0]   pc_q;
  logic [InstWidth-1:0] inst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      pc_q    <= load_pc;
      inst_q  <= load_inst;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign inst  = inst_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake, applies redirects.
// Optional FETCH_MISALIGN_CHECK_EN: ignore misaligned redirects and raise sticky misalign_err.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [PcWidth-1:0]   redirect_pc,
  output logic                 imem_req,
  output logic [PcWidth-1:0]   imem_addr,
  input  logic                 imem_ack,
  input  logic [InstWidth-1:0] imem_rdata,
  output logic                 if_valid,
  output logic [PcWidth-1:0]   if_pc,
  output logic [InstWidth-1:0] if_inst,
  input  logic                 if_ready,
  output logic                 misalign_err
);

  fetch_state_e       state_q, state_d;
  logic [PcWidth-1:0] pc_q, pc_d;
  logic [PcWidth-1:0] pend_pc_q, pend_pc_d;
  logic               redir_take;
  logic [PcWidth-1:0] redir_tgt;
  logic               buf_load;
  logic               space;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  assign redir_take = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_tgt  = redirect_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_q;
`else
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redir_take          = redirect_valid;
  assign redir_tgt           = {redirect_pc[PcWidth-1:2], 2'b00};
  assign misalign_err        = 1'b0;
`endif

  assign space = !if_valid || if_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    buf_load  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (redir_take) begin
          pc_d = redir_tgt;
        end else if (space) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (redir_take && imem_ack) begin
          pc_d    = redir_tgt;
          state_d = StIdle;
        end else if (redir_take) begin
          // Keep pc so imem_addr stays stable until the abandoned request is acked.
          pend_pc_d = redir_tgt;
          state_d   = StDrain;
        end else if (imem_ack) begin
          buf_load = 1'b1;
          pc_d     = next_seq_pc(pc_q);
          state_d  = StIdle;
        end
      end
      StDrain: begin
        if (redir_take) begin
          pend_pc_d = redir_tgt;
        end
        if (imem_ack) begin
          pc_d    = redir_take ? redir_tgt : pend_pc_q;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  fetch_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .consume   (if_valid && if_ready),
    .flush     (redir_take),
    .load_pc   (pc_q),
    .load_inst (imem_rdata),
    .valid     (if_valid),
    .pc        (if_pc),
    .inst      (if_inst)
  );

  assign imem_req  = (state_q != StIdle);
  assign imem_addr = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl: one record per cycle of inputs and expected outputs.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        misalign_err;

  int tests;
  int fails;

  fetch_ctrl #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_ready       (if_ready),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied during a cycle, and the registered outputs expected in that same cycle.
  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] ipc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic ack,
                       input logic [31:0] rdata, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ack       = ack;
    imem_rdata     = rdata;
    if_ready       = rdy;
  endtask

  task automatic add(input logic rv, input logic [31:0] rpc, input logic ack,
                     input logic [31:0] rdata, input logic rdy, input logic req,
                     input logic [31:0] addr, input logic v, input logic [31:0] ipc,
                     input logic [31:0] inst);
    vec_t t;
    t.rv = rv; t.rpc = rpc; t.ack = ack; t.rdata = rdata; t.rdy = rdy;
    t.req = req; t.addr = addr; t.v = v; t.ipc = ipc; t.inst = inst;
    vecs.push_back(t);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    //  rv  rpc           ack rdata         rdy  req addr          v   ipc           inst
    add(0, 32'h0,       0, 32'h0,       1,   0, 32'h0000_0000, 0, 32'h0,       32'h0);
    add(0, 32'h0,       1, 32'hA000_0000, 1, 1, 32'h0000_0000, 0, 32'h0,       32'h0);
    add(0, 32'h0,       0, 32'h0,       1,   0, 32'h0000_0004, 1, 32'h0,       32'hA000_0000);
    add(0, 32'h0,       1, 32'hA000_0001, 1, 1, 32'h0000_0004, 0, 32'h0,       32'h0);
    add(0, 32'h0,       0, 32'h0,       1,   0, 32'h0000_0008, 1, 32'h4,       32'hA000_0001);
    add(0, 32'h0,       1, 32'hA000_0002, 1, 1, 32'h0000_0008, 0, 32'h0,       32'h0);
    for (int i = 0; i < 5; i++) begin
      add(0, 32'h0,     0, 32'h0,       0,   0, 32'h0000_000C, 1, 32'h8,       32'hA000_0002);
    end
    add(0, 32'h0,       0, 32'h0,       1,   0, 32'h0000_000C, 1, 32'h8,       32'hA000_0002);
    // Redirect while waiting on a slow ack; the late data must be dropped.
    add(1, 32'h100,     0, 32'h0,       1,   1, 32'h0000_000C, 0, 32'h0,       32'h0);
    add(0, 32'h0,       0, 32'h0,       1,   1, 32'h0000_000C, 0, 32'h0,       32'h0);
    add(0, 32'h0,       0, 32'h0,       1,   1, 32'h0000_000C, 0, 32'h0,       32'h0);
    add(0, 32'h0,       1, 32'hDEAD_BEEF, 1, 1, 32'h0000_000C, 0, 32'h0,       32'h0);
    add(0, 32'h0,       0, 32'h0,       1,   0, 32'h0000_0100, 0, 32'h0,       32'h0);
    // Two redirects in one drain: last one wins.
    add(1, 32'h200,     0, 32'h0,       1,   1, 32'h0000_0100, 0, 32'h0,       32'h0);
    add(1, 32'h300,     0, 32'h0,       1,   1, 32'h0000_0100, 0, 32'h0,       32'h0);
    add(0, 32'h0,       1, 32'hBAD0_0000, 1, 1, 32'h0000_0100, 0, 32'h0,       32'h0);
    add(0, 32'h0,       0, 32'h0,       1,   0, 32'h0000_0300, 0, 32'h0,       32'h0);
    add(0, 32'h0,       1, 32'hB000_0000, 1, 1, 32'h0000_0300, 0, 32'h0,       32'h0);
    add(0, 32'h0,       0, 32'h0,       1,   0, 32'h0000_0304, 1, 32'h300,     32'hB000_0000);
    // Redirect coinciding with ack and if_ready.
    add(1, 32'h400,     1, 32'hBAD0_0001, 1, 1, 32'h0000_0304, 0, 32'h0,       32'h0);
    add(0, 32'h0,       0, 32'h0,       1,   0, 32'h0000_0400, 0, 32'h0,       32'h0);
    add(0, 32'h0,       1, 32'hC000_0000, 1, 1, 32'h0000_0400, 0, 32'h0,       32'h0);
    // Redirect flushes a valid, unconsumed buffer.
    add(1, 32'h500,     0, 32'h0,       0,   0, 32'h0000_0404, 1, 32'h400,     32'hC000_0000);
    add(0, 32'h0,       0, 32'h0,       1,   0, 32'h0000_0500, 0, 32'h0,       32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req", {31'b0, imem_req}, 32'h0);
    check("reset_addr", imem_addr, 32'h0);
    check("reset_valid", {31'b0, if_valid}, 32'h0);
    check("reset_if_pc", if_pc, 32'h0);
    check("reset_if_inst", if_inst, 32'h0);
    check("reset_misalign", {31'b0, misalign_err}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i].rv, vecs[i].rpc, vecs[i].ack, vecs[i].rdata, vecs[i].rdy);
      check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("v%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].v});
      if (vecs[i].v) begin
        check($sformatf("v%0d_if_pc", i), if_pc, vecs[i].ipc);
        check($sformatf("v%0d_if_inst", i), if_inst, vecs[i].inst);
      end
      check($sformatf("v%0d_misalign", i), {31'b0, misalign_err}, 32'h0);
    end

    // Misaligned redirect to 0x102 while a request to 0x500 is outstanding.
    @(negedge clk);
    drive(1'b1, 32'h0000_0102, 1'b0, 32'h0, 1'b1);
    check("mis_a_req", {31'b0, imem_req}, 32'h1);
    check("mis_a_addr", imem_addr, 32'h500);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b1);
    check("mis_b_req", {31'b0, imem_req}, 32'h1);
    check("mis_b_addr", imem_addr, 32'h500);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_b_err", {31'b0, misalign_err}, 32'h1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("mis_c_addr", imem_addr, 32'h504);
    check("mis_c_valid", {31'b0, if_valid}, 32'h1);
    check("mis_c_if_pc", if_pc, 32'h500);
    check("mis_c_if_inst", if_inst, 32'h1234_5678);
    check("mis_c_err", {31'b0, misalign_err}, 32'h1);
`else
    check("mis_b_err", {31'b0, misalign_err}, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("mis_c_req", {31'b0, imem_req}, 32'h0);
    check("mis_c_addr", imem_addr, 32'h100);
    check("mis_c_valid", {31'b0, if_valid}, 32'h0);
    @(negedge clk);
    check("mis_d_req", {31'b0, imem_req}, 32'h1);
    check("mis_d_addr", imem_addr, 32'h100);
`endif

    // Reset mid-stream, then PC wrap from 0xFFFF_FFFC to 0.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("rst2_req", {31'b0, imem_req}, 32'h0);
    check("rst2_addr", imem_addr, 32'h0);
    check("rst2_valid", {31'b0, if_valid}, 32'h0);
    check("rst2_misalign", {31'b0, misalign_err}, 32'h0);
    rst = 1'b0;
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("wrap_a_req", {31'b0, imem_req}, 32'h0);
    check("wrap_a_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'hE000_0000, 1'b1);
    check("wrap_b_req", {31'b0, imem_req}, 32'h1);
    check("wrap_b_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("wrap_c_req", {31'b0, imem_req}, 32'h0);
    check("wrap_c_addr", imem_addr, 32'h0);
    check("wrap_c_valid", {31'b0, if_valid}, 32'h1);
    check("wrap_c_if_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_c_if_inst", if_inst, 32'hE000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
